// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-back write-allocate data cache with halt flush
module dcache_dm #(
  parameter int          SETS        = 16,
  parameter logic [31:0] HITCNT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] WB0  = 4'd1;
  localparam logic [3:0] WB1  = 4'd2;
  localparam logic [3:0] RD0  = 4'd3;
  localparam logic [3:0] RD1  = 4'd4;
  localparam logic [3:0] FCHK = 4'd5;
  localparam logic [3:0] FWB0 = 4'd6;
  localparam logic [3:0] FWB1 = 4'd7;
  localparam logic [3:0] CNT  = 4'd8;
  localparam logic [3:0] DONE = 4'd9;

  logic [3:0]    state;
  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;
  logic [TW-1:0] tags  [SETS];
  logic [31:0]   data0 [SETS];
  logic [31:0]   data1 [SETS];
  logic [28:0]   req_blk;
  logic [IW-1:0] fidx;
  logic [31:0]   hit_cnt;

  logic [TW-1:0] cur_tag;
  logic [IW-1:0] cur_idx;
  logic          cur_off;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic          request;
  logic          hit_way;
  logic          unused_addr_bits;

  assign cur_tag          = dmemaddr[31:3+IW];
  assign cur_idx          = dmemaddr[2+IW:3];
  assign cur_off          = dmemaddr[2];
  assign req_tag          = req_blk[28:IW];
  assign req_idx          = req_blk[IW-1:0];
  assign unused_addr_bits = ^dmemaddr[1:0];

  assign request  = dmemREN | dmemWEN;
  assign hit_way  = valid[cur_idx] && (tags[cur_idx] == cur_tag);
  // Halt wins over a same-cycle request so the flush never races a store.
  assign dhit     = (state == IDLE) && !halt && request && hit_way;
  assign dmemload = cur_off ? data1[cur_idx] : data0[cur_idx];
  assign flushed  = (state == DONE);

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'h0;
    dstore = 32'h0;
    case (state)
      WB0: begin
        dWEN   = 1'b1;
        daddr  = {tags[req_idx], req_idx, 1'b0, 2'b00};
        dstore = data0[req_idx];
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {tags[req_idx], req_idx, 1'b1, 2'b00};
        dstore = data1[req_idx];
      end
      RD0: begin
        dREN  = 1'b1;
        daddr = {req_blk, 1'b0, 2'b00};
      end
      RD1: begin
        dREN  = 1'b1;
        daddr = {req_blk, 1'b1, 2'b00};
      end
      FWB0: begin
        dWEN   = 1'b1;
        daddr  = {tags[fidx], fidx, 1'b0, 2'b00};
        dstore = data0[fidx];
      end
      FWB1: begin
        dWEN   = 1'b1;
        daddr  = {tags[fidx], fidx, 1'b1, 2'b00};
        dstore = data1[fidx];
      end
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hit_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      valid   <= '0;
      dirty   <= '0;
      req_blk <= '0;
      fidx    <= '0;
      hit_cnt <= '0;
      for (int i = 0; i < SETS; i++) begin
        tags[i]  <= '0;
        data0[i] <= '0;
        data1[i] <= '0;
      end
    end else begin
      if (dhit) hit_cnt <= hit_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (halt) begin
            fidx  <= '0;
            state <= FCHK;
          end else if (request && !hit_way) begin
            // The refill address is latched so daddr stays stable while dwait holds.
            req_blk <= dmemaddr[31:3];
            state   <= (valid[cur_idx] && dirty[cur_idx]) ? WB0 : RD0;
          end else if (dhit && dmemWEN) begin
            if (cur_off) data1[cur_idx] <= dmemstore;
            else         data0[cur_idx] <= dmemstore;
            dirty[cur_idx] <= 1'b1;
          end
        end
        WB0: if (!dwait) state <= WB1;
        WB1: if (!dwait) state <= RD0;
        RD0: begin
          if (!dwait) begin
            data0[req_idx] <= dload;
            state          <= RD1;
          end
        end
        RD1: begin
          if (!dwait) begin
            data1[req_idx] <= dload;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            tags[req_idx]  <= req_tag;
            state          <= IDLE;
          end
        end
        FCHK: begin
          if (dirty[fidx])                state <= FWB0;
          else if (fidx == IW'(SETS - 1)) state <= CNT;
          else                            fidx  <= fidx + IW'(1);
        end
        FWB0: if (!dwait) state <= FWB1;
        FWB1: begin
          if (!dwait) begin
            dirty[fidx] <= 1'b0;
            if (fidx == IW'(SETS - 1)) begin
              state <= CNT;
            end else begin
              fidx  <= fidx + IW'(1);
              state <= FCHK;
            end
          end
        end
        CNT:     if (!dwait) state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - scoreboard bench for dcache_dm
module tb_dcache_dm;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = 32'h0;
  logic [31:0] dmemstore = 32'h0;
  logic        dwait = 1'b0;
  logic [31:0] dload = 32'h0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;

  dcache_dm #(.SETS(16), .HITCNT_ADDR(32'h00003100)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} mem_t;
  typedef struct packed {logic chk; logic [31:0] data;} hit_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [31:0]];
  mem_t        mem_q[$];
  hit_t        hit_q[$];
  mem_t        mon_e;
  hit_t        mon_h;
  int          wait_cycles = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_store;
  logic        prev_ren, prev_wen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder and scoreboard monitor share one process so dwait is settled before checking.
  always @(negedge CLK) begin
    if (!nRST) begin
      prev_stall = 1'b0;
      dwait      = 1'b0;
    end else begin
      if (dREN || dWEN) begin
        if (wait_cycles > 0) begin
          dwait = 1'b1;
          wait_cycles--;
        end else begin
          dwait = (daddr == stall_addr);
        end
      end else begin
        dwait = 1'b0;
      end
      dload = mem.exists(daddr) ? mem[daddr] : 32'h0;
      if (prev_stall) begin
        check("stable_daddr", daddr, prev_addr);
        check("stable_dstore", dstore, prev_store);
        check("stable_req", {30'b0, dREN, dWEN}, {30'b0, prev_ren, prev_wen});
      end
      prev_stall = (dREN || dWEN) && dwait;
      prev_addr  = daddr;
      prev_store = dstore;
      prev_ren   = dREN;
      prev_wen   = dWEN;
      if ((dREN || dWEN) && !dwait) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got we=%0d addr %h expected no transaction", dWEN, daddr);
        end else begin
          mon_e = mem_q.pop_front();
          check("mem_op", {31'b0, dWEN}, {31'b0, mon_e.we});
          check("mem_addr", daddr, mon_e.addr);
          if (mon_e.we) check("mem_wdata", dstore, mon_e.data);
        end
        if (dWEN) mem[daddr] = dstore;
      end
      if (dhit) begin
        if (hit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hit_unexpected: got dhit at addr %h expected none", dmemaddr);
        end else begin
          mon_h = hit_q.pop_front();
          if (mon_h.chk) check("load_data", dmemload, mon_h.data);
        end
      end
    end
  end

  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input string name);
    int lat = 0;
    bit got = 0;
    @(posedge CLK); #1;
    dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      if (dhit) got = 1;
      else lat++;
    end
    if (!got) lat = -1;
    check({name, "_latency"}, lat, exp_lat);
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp, input int lat, input string name);
    hit_q.push_back('{1'b1, exp});
    access(1'b1, 1'b0, addr, 32'h0, lat, name);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input int lat,
                       input logic both, input string name);
    hit_q.push_back('{1'b0, 32'h0});
    access(both, 1'b1, addr, data, lat, name);
  endtask

  task automatic exp_rd(input logic [31:0] addr);
    mem_q.push_back('{1'b0, addr, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
    mem_q.push_back('{1'b1, addr, data});
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  found;
    mem[32'h40] = 32'h11111111;
    mem[32'h44] = 32'h22222222;
    mem[32'hC0] = 32'h33333333;
    mem[32'hC4] = 32'h44444444;
    mem[32'h50] = 32'h55555555;

    repeat (2) @(negedge CLK);
    check("rst_dhit", {31'b0, dhit}, 32'h0);
    check("rst_dren", {31'b0, dREN}, 32'h0);
    check("rst_dwen", {31'b0, dWEN}, 32'h0);
    check("rst_daddr", daddr, 32'h0);
    check("rst_dstore", dstore, 32'h0);
    check("rst_flushed", {31'b0, flushed}, 32'h0);
    check("rst_dmemload", dmemload, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    exp_rd(32'h40); exp_rd(32'h44);
    load(32'h40, 32'h11111111, 3, "clean_miss");
    load(32'h44, 32'h22222222, 0, "hit_word1");
    store(32'h40, 32'hDEADBEEF, 0, 1'b1, "store_hit_both");
    load(32'h40, 32'hDEADBEEF, 0, "load_after_store");

    exp_wr(32'h40, 32'hDEADBEEF); exp_wr(32'h44, 32'h22222222);
    exp_rd(32'hC0); exp_rd(32'hC4);
    load(32'hC0, 32'h33333333, 5, "dirty_miss");

    wait_cycles = 3;
    exp_rd(32'h50); exp_rd(32'h54);
    load(32'h50, 32'h55555555, 6, "stall_miss");

    store(32'hC0, 32'h66666666, 0, 1'b0, "dirty_c0");
    exp_wr(32'hC0, 32'h66666666);
    stall_addr = 32'hC4;
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (dWEN && daddr == 32'hC4) found = 1;
    end
    check("wb1_reached", {31'b0, found}, 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    check("midrst_dwen", {31'b0, dWEN}, 32'h0);
    check("midrst_dren", {31'b0, dREN}, 32'h0);
    check("midrst_daddr", daddr, 32'h0);
    dmemREN = 1'b0;
    stall_addr = 32'hFFFF_FFFF;
    @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_rd(32'hC0); exp_rd(32'hC4);
    load(32'hC0, 32'h66666666, 3, "post_rst_miss_c0");
    exp_rd(32'h50); exp_rd(32'h54);
    load(32'h50, 32'h55555555, 3, "post_rst_miss_50");
    check("mem_q_drained", mem_q.size(), 32'h0);

    do_reset();
    exp_rd(32'h10); exp_rd(32'h14);
    store(32'h10, 32'hAAAA0001, 3, 1'b0, "store_miss_f2");
    exp_rd(32'h28); exp_rd(32'h2C);
    store(32'h2C, 32'hBBBB0005, 3, 1'b0, "store_miss_f5");
    load(32'h10, 32'hAAAA0001, 0, "f2_w0");
    load(32'h14, 32'h0, 0, "f2_w1");
    load(32'h2C, 32'hBBBB0005, 0, "f5_w1");
    load(32'h28, 32'h0, 0, "f5_w0");
    load(32'h10, 32'hAAAA0001, 0, "f2_w0_again");

    exp_wr(32'h10, 32'hAAAA0001); exp_wr(32'h14, 32'h0);
    exp_wr(32'h28, 32'h0); exp_wr(32'h2C, 32'hBBBB0005);
    exp_wr(32'h3100, 32'h7);
    @(posedge CLK); #1;
    halt = 1'b1;
    lat = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (flushed) found = 1;
      else lat++;
    end
    check("flush_cycles", lat, 32'd22);
    repeat (5) begin
      @(negedge CLK);
      check("flushed_held", {31'b0, flushed}, 32'h1);
      check("done_quiet", {30'b0, dREN, dWEN}, 32'h0);
    end
    check("mem_q_empty", mem_q.size(), 32'h0);
    check("hit_q_empty", hit_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
